// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, state encoding and datapath select encodings for the main control FSM
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EX, S_R_WB, S_BEQ, S_JMP, S_ADDI_EX, S_ADDI_WB
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the shared memory port and are covered by the watchdog.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle main control FSM with memory watchdog and retire counter
module mc_main_control #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);
  import mc_pkg::*;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t          state, state_n;
  logic [WD_W-1:0] wdog;
  logic            wait_cyc, wd_expire, retire, bad_op;

  // The branch decision is made in the datapath from pc_write_cond and zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    wait_cyc  = is_mem_state(state) && !mem_ready;
    wd_expire = (TIMEOUT != 0) && wait_cyc && (wdog == WD_W'(TIMEOUT - 1));
    state_n   = state;
    retire    = 1'b0;
    bad_op    = 1'b0;
    case (state)
      S_IDLE:     state_n = S_FETCH;
      S_FETCH:    if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_n = S_R_EX;
          OP_LW, OP_SW: state_n = S_MEM_ADDR;
          OP_BEQ:       state_n = S_BEQ;
          OP_J:         state_n = S_JMP;
          OP_ADDI:      state_n = S_ADDI_EX;
          default: begin
            bad_op  = 1'b1;
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: state_n = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_n = S_MEM_WB;
      S_MEM_WB: begin
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_n = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EX:     state_n = S_R_WB;
      S_ADDI_EX:  state_n = S_ADDI_WB;
      S_R_WB, S_BEQ, S_JMP, S_ADDI_WB: begin
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      default:    state_n = S_IDLE;
    endcase
    // An expired access is dropped: no retire, restart from a fresh fetch.
    if (wd_expire) begin
      state_n = S_FETCH;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wdog        <= '0;
      instr_count <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (wd_expire || (state_n != state)) wdog <= '0;
      else if (wait_cyc)                   wdog <= wdog + WD_W'(1);
      if (retire)    instr_count <= instr_count + CNT_W'(1);
      if (bad_op)    illegal_op  <= 1'b1;
      if (wd_expire) mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB:  reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule
